// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: single-cycle AMCI write/read strobes become full AW+W+B / AR+R transactions.
// Latency: strobe at cycle N -> AWVALID/WVALID (or ARVALID) at N+1; completion one edge after B/R handshake.
// Backpressure: each engine waits indefinitely on slave READY/VALID; strobes arriving while busy are dropped.
//
// Ports: clk/resetn (async active-low); AMCI_* user request/response side; M_AXI_* AXI4-Lite master side.
// Build option: define AXIL_WSTRB_EN to add the AMCI_WSTRB input; otherwise M_AXI_WSTRB is all ones.
module axi4_lite_master #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  // user write side
  input  logic [AW-1:0] AMCI_WADDR,
  input  logic [31:0]   AMCI_WDATA,
`ifdef AXIL_WSTRB_EN
  input  logic [3:0]    AMCI_WSTRB,
`endif
  input  logic          AMCI_WRITE,
  output logic [1:0]    AMCI_WRESP,
  output logic          AMCI_WIDLE,
  // user read side
  input  logic [AW-1:0] AMCI_RADDR,
  input  logic          AMCI_READ,
  output logic [31:0]   AMCI_RDATA,
  output logic [1:0]    AMCI_RRESP,
  output logic          AMCI_RIDLE,
  // AXI write address / data / response
  output logic [AW-1:0] M_AXI_AWADDR,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [2:0]    M_AXI_AWPROT,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  // AXI read address / data
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  output logic [2:0]    M_AXI_ARPROT,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t       wstate, wstate_n;
  rstate_t       rstate, rstate_n;

  logic [AW-1:0] awaddr_q, awaddr_n;
  logic [31:0]   wdata_q, wdata_n;
  logic          awvalid_q, awvalid_n;
  logic          wvalid_q, wvalid_n;
  logic          bready_q, bready_n;
  logic [1:0]    wresp_q, wresp_n;

  logic [AW-1:0] araddr_q, araddr_n;
  logic          arvalid_q, arvalid_n;
  logic          rready_q, rready_n;
  logic [31:0]   rdata_q, rdata_n;
  logic [1:0]    rresp_q, rresp_n;

`ifdef AXIL_WSTRB_EN
  logic [3:0]    wstrb_q, wstrb_n;
  assign M_AXI_WSTRB = wstrb_q;
`else
  assign M_AXI_WSTRB = 4'hF;
`endif

  // ---------------- write engine ----------------
  always_comb begin
    wstate_n  = wstate;
    awaddr_n  = awaddr_q;
    wdata_n   = wdata_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    bready_n  = bready_q;
    wresp_n   = wresp_q;
`ifdef AXIL_WSTRB_EN
    wstrb_n   = wstrb_q;
`endif
    case (wstate)
      W_IDLE: begin
        if (AMCI_WRITE) begin
          awaddr_n  = AMCI_WADDR;
          wdata_n   = AMCI_WDATA;
`ifdef AXIL_WSTRB_EN
          wstrb_n   = AMCI_WSTRB;
`endif
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          wstate_n  = W_ADDR;
        end
      end
      W_ADDR: begin
        // Each VALID clears independently on its own handshake; moving on once
        // both next-values are low also covers the same-edge completion case.
        awvalid_n = awvalid_q && !M_AXI_AWREADY;
        wvalid_n  = wvalid_q && !M_AXI_WREADY;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          wstate_n = W_RESP;
        end
      end
      W_RESP: begin
        if (M_AXI_BVALID) begin
          wresp_n  = M_AXI_BRESP;
          bready_n = 1'b0;
          wstate_n = W_IDLE;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate    <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wresp_q   <= 2'b00;
`ifdef AXIL_WSTRB_EN
      wstrb_q   <= 4'h0;
`endif
    end else begin
      wstate    <= wstate_n;
      awaddr_q  <= awaddr_n;
      wdata_q   <= wdata_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      wresp_q   <= wresp_n;
`ifdef AXIL_WSTRB_EN
      wstrb_q   <= wstrb_n;
`endif
    end
  end

  // ---------------- read engine ----------------
  always_comb begin
    rstate_n  = rstate;
    araddr_n  = araddr_q;
    arvalid_n = arvalid_q;
    rready_n  = rready_q;
    rdata_n   = rdata_q;
    rresp_n   = rresp_q;
    case (rstate)
      R_IDLE: begin
        if (AMCI_READ) begin
          araddr_n  = AMCI_RADDR;
          arvalid_n = 1'b1;
          rstate_n  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          rstate_n  = R_DATA;
        end
      end
      R_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_n  = M_AXI_RDATA;
          rresp_n  = M_AXI_RRESP;
          rready_n = 1'b0;
          rstate_n = R_IDLE;
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate    <= R_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rstate    <= rstate_n;
      araddr_q  <= araddr_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
    end
  end

  // ---------------- outputs ----------------
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;

  assign AMCI_WRESP = wresp_q;
  assign AMCI_RRESP = rresp_q;
  assign AMCI_RDATA = rdata_q;
  // A strobe in the current cycle already counts as busy.
  assign AMCI_WIDLE = (wstate == W_IDLE) && !AMCI_WRITE;
  assign AMCI_RIDLE = (rstate == R_IDLE) && !AMCI_READ;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Testbench for axi4_lite_master: configurable-latency AXI4-Lite slave model plus a
// scoreboard of expected AW/W/B/AR/R traffic, checked on the falling clock edge.
// Works for both builds (with and without AXIL_WSTRB_EN).
module tb_axi4_lite_master;

  logic        clk, resetn;
  logic [31:0] AMCI_WADDR, AMCI_WDATA, AMCI_RADDR, AMCI_RDATA;
  logic [3:0]  AMCI_WSTRB;
  logic        AMCI_WRITE, AMCI_READ, AMCI_WIDLE, AMCI_RIDLE;
  logic [1:0]  AMCI_WRESP, AMCI_RRESP;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  axi4_lite_master #(.AW(32)) dut (
    .clk(clk), .resetn(resetn),
    .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA),
`ifdef AXIL_WSTRB_EN
    .AMCI_WSTRB(AMCI_WSTRB),
`endif
    .AMCI_WRITE(AMCI_WRITE), .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
    .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ), .AMCI_RDATA(AMCI_RDATA),
    .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strb_exp(input logic [3:0] s);
`ifdef AXIL_WSTRB_EN
    return s;
`else
    return 4'hF;
`endif
  endfunction

  // slave response configuration (cycles of stall before READY / VALID)
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // scoreboard queues
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];   // {data, strb}
  logic [1:0]  exp_b[$];
  logic [31:0] exp_ar[$];
  logic [33:0] exp_r[$];   // {data, resp}

  int cyc_cnt = 0, aw_hs_cnt = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  bit b_pend = 0, r_pend = 0;
  logic [1:0]  b_exp;
  logic [33:0] r_exp;

  // Slave model: inputs change only at posedge+1, so negedge values equal edge values.
  initial begin : slave
    int awc, wc, bc, arc, rc;
    awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    forever begin
      @(posedge clk); #1;
      M_AXI_AWREADY = 0;
      if (M_AXI_AWVALID) begin
        if (awc >= aw_lat) begin M_AXI_AWREADY = 1; awc = 0; end else awc++;
      end else awc = 0;
      M_AXI_WREADY = 0;
      if (M_AXI_WVALID) begin
        if (wc >= w_lat) begin M_AXI_WREADY = 1; wc = 0; end else wc++;
      end else wc = 0;
      if (M_AXI_BVALID) begin
        if (!M_AXI_BREADY) M_AXI_BVALID = 0;
      end else if (M_AXI_BREADY) begin
        if (bc >= b_lat) begin M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg; bc = 0; end else bc++;
      end else bc = 0;
      M_AXI_ARREADY = 0;
      if (M_AXI_ARVALID) begin
        if (arc >= ar_lat) begin M_AXI_ARREADY = 1; arc = 0; end else arc++;
      end else arc = 0;
      if (M_AXI_RVALID) begin
        if (!M_AXI_RREADY) M_AXI_RVALID = 0;
      end else if (M_AXI_RREADY) begin
        if (rc >= r_lat) begin
          M_AXI_RVALID = 1; M_AXI_RDATA = rdata_cfg; M_AXI_RRESP = rresp_cfg; rc = 0;
        end else rc++;
      end else rc = 0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    cyc_cnt++;
    if (!resetn) begin
      exp_aw.delete(); exp_w.delete(); exp_b.delete(); exp_ar.delete(); exp_r.delete();
      b_pend = 0; r_pend = 0;
    end else begin
      if (b_pend) begin chk("amci_wresp", AMCI_WRESP, b_exp); b_pend = 0; end
      if (r_pend) begin
        chk("amci_rdata", AMCI_RDATA, r_exp[33:2]);
        chk("amci_rresp", AMCI_RRESP, r_exp[1:0]);
        r_pend = 0;
      end
      if (M_AXI_AWVALID && exp_aw.size() != 0) chk("awaddr_hold", M_AXI_AWADDR, exp_aw[0]);
      if (M_AXI_WVALID && exp_w.size() != 0) chk("wdata_strb_hold", {M_AXI_WDATA, M_AXI_WSTRB}, exp_w[0]);
      if (M_AXI_ARVALID && exp_ar.size() != 0) chk("araddr_hold", M_AXI_ARADDR, exp_ar[0]);
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_hs_cnt++; aw_hs_cyc = cyc_cnt;
        chk("aw_hs_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) void'(exp_aw.pop_front());
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_hs_cyc = cyc_cnt;
        chk("w_hs_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) void'(exp_w.pop_front());
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        chk("b_hs_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin b_exp = exp_b.pop_front(); b_pend = 1; end
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        chk("ar_hs_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) void'(exp_ar.pop_front());
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        chk("r_hs_expected", exp_r.size() != 0, 1);
        if (exp_r.size() != 0) begin r_exp = exp_r.pop_front(); r_pend = 1; end
      end
    end
  end

  // Returns cycles spent waiting; an expired bound shows up as a failed idle check.
  task automatic wait_idle(input bit wr, input int max, output int cyc);
    cyc = 0;
    while ((wr ? !AMCI_WIDLE : !AMCI_RIDLE) && cyc < max) begin
      @(posedge clk); #1; cyc++;
    end
    chk(wr ? "widle_reached" : "ridle_reached", wr ? AMCI_WIDLE : AMCI_RIDLE, 1);
  endtask

  // Call at posedge+1.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] br, input int max, output int cyc);
    bresp_cfg = br;
    exp_aw.push_back(a); exp_w.push_back({d, strb_exp(s)}); exp_b.push_back(br);
    AMCI_WADDR = a; AMCI_WDATA = d; AMCI_WSTRB = s; AMCI_WRITE = 1;
    #1 chk("widle_low_on_strobe", AMCI_WIDLE, 0);
    @(posedge clk); #1;
    AMCI_WRITE = 0;
    chk("awvalid_at_n1", M_AXI_AWVALID, 1);
    chk("wvalid_at_n1", M_AXI_WVALID, 1);
    wait_idle(1, max, cyc);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr,
                         input int max, output int cyc);
    rdata_cfg = d; rresp_cfg = rr;
    exp_ar.push_back(a); exp_r.push_back({d, rr});
    AMCI_RADDR = a; AMCI_READ = 1;
    #1 chk("ridle_low_on_strobe", AMCI_RIDLE, 0);
    @(posedge clk); #1;
    AMCI_READ = 0;
    chk("arvalid_at_n1", M_AXI_ARVALID, 1);
    wait_idle(0, max, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, M_AXI_AWVALID, 0);
    chk({tag, "_wvalid"}, M_AXI_WVALID, 0);
    chk({tag, "_bready"}, M_AXI_BREADY, 0);
    chk({tag, "_arvalid"}, M_AXI_ARVALID, 0);
    chk({tag, "_rready"}, M_AXI_RREADY, 0);
    chk({tag, "_wresp"}, AMCI_WRESP, 0);
    chk({tag, "_rresp"}, AMCI_RRESP, 0);
    chk({tag, "_rdata"}, AMCI_RDATA, 0);
    chk({tag, "_awaddr"}, M_AXI_AWADDR, 0);
    chk({tag, "_wdata"}, M_AXI_WDATA, 0);
    chk({tag, "_araddr"}, M_AXI_ARADDR, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin : main
    int cyc, hs0;
    resetn = 0; AMCI_WRITE = 0; AMCI_READ = 0;
    AMCI_WADDR = 0; AMCI_WDATA = 0; AMCI_WSTRB = 0; AMCI_RADDR = 0;
    #2;
    chk_reset_outputs("rst");
    chk("rst_awprot", M_AXI_AWPROT, 0);
    chk("rst_arprot", M_AXI_ARPROT, 0);
    chk("rst_widle", AMCI_WIDLE, 1);
    chk("rst_ridle", AMCI_RIDLE, 1);
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    @(posedge clk); #1;

    // 1: simple write, same-cycle AW/W ready, immediate B
    aw_lat = 0; w_lat = 0; b_lat = 0;
    do_write(32'h10, 32'hDEADBEEF, 4'b0101, 2'b00, 10, cyc);
    chk("t1_widle_by_n4", cyc <= 3, 1);
    @(posedge clk); #1;

    // 2: W accepted 3 cycles before AW, B delayed 5 cycles, SLVERR/DECERR resp
    aw_lat = 3; w_lat = 0; b_lat = 5;
    do_write(32'h10, 32'hCAFEF00D, 4'b1100, 2'b11, 30, cyc);
    chk("t2_w_before_aw", w_hs_cyc < aw_hs_cyc, 1);
    @(posedge clk); #1;
    chk("t2_wresp_hold", AMCI_WRESP, 2'b11);

    // 3: read with 2-cycle ARREADY stall
    ar_lat = 2; r_lat = 0;
    do_read(32'h04, 32'h12345678, 2'b00, 20, cyc);
    @(posedge clk); #1;

    // 4: concurrent write + read, then a second write strobe while busy
    aw_lat = 2; w_lat = 1; b_lat = 1; ar_lat = 1; r_lat = 1;
    bresp_cfg = 2'b10; rdata_cfg = 32'hA5A5_0F0F; rresp_cfg = 2'b01;
    hs0 = aw_hs_cnt;
    exp_aw.push_back(32'h20); exp_w.push_back({32'h11112222, strb_exp(4'b0011)}); exp_b.push_back(2'b10);
    exp_ar.push_back(32'h30); exp_r.push_back({32'hA5A5_0F0F, 2'b01});
    AMCI_WADDR = 32'h20; AMCI_WDATA = 32'h11112222; AMCI_WSTRB = 4'b0011; AMCI_WRITE = 1;
    AMCI_RADDR = 32'h30; AMCI_READ = 1;
    @(posedge clk); #1;
    AMCI_WRITE = 0; AMCI_READ = 0;
    chk("t4_awvalid", M_AXI_AWVALID, 1);
    chk("t4_arvalid", M_AXI_ARVALID, 1);
    @(posedge clk); #1;
    AMCI_WADDR = 32'h99; AMCI_WDATA = 32'hBAD0BAD0; AMCI_WSTRB = 4'b1000; AMCI_WRITE = 1;
    #1 chk("t4_widle_busy", AMCI_WIDLE, 0);
    @(posedge clk); #1;
    AMCI_WRITE = 0;
    wait_idle(1, 30, cyc);
    wait_idle(0, 30, cyc);
    repeat (2) @(posedge clk);
    #1 chk("t4_single_aw_hs", aw_hs_cnt - hs0, 1);

    // 5: reset mid-transaction
    aw_lat = 10; w_lat = 10; b_lat = 0; ar_lat = 0; r_lat = 10;
    exp_aw.push_back(32'h40); exp_w.push_back({32'h0, strb_exp(4'hF)}); exp_b.push_back(2'b00);
    exp_ar.push_back(32'h44); exp_r.push_back({32'h0, 2'b00});
    AMCI_WADDR = 32'h40; AMCI_WDATA = 32'h0; AMCI_WSTRB = 4'hF; AMCI_WRITE = 1;
    AMCI_RADDR = 32'h44; AMCI_READ = 1;
    @(posedge clk); #1;
    AMCI_WRITE = 0; AMCI_READ = 0;
    @(posedge clk); #1;
    chk("t5_pre_awvalid", M_AXI_AWVALID, 1);
    chk("t5_pre_rready", M_AXI_RREADY, 1);
    #1 resetn = 0;
    #1 chk_reset_outputs("t5");
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    @(posedge clk); #1;
    aw_lat = 0; w_lat = 0; b_lat = 0;
    do_write(32'h50, 32'h0BADF00D, 4'b0101, 2'b01, 10, cyc);
    chk("t5_post_widle_by_n4", cyc <= 3, 1);
    @(posedge clk); #1;

    // 6: another strobe pattern through the WSTRB path
    do_write(32'h54, 32'h76543210, 4'b1010, 2'b00, 10, cyc);

    repeat (3) @(posedge clk);
    #1;
    chk("end_aw_q_empty", exp_aw.size(), 0);
    chk("end_w_q_empty", exp_w.size(), 0);
    chk("end_b_q_empty", exp_b.size(), 0);
    chk("end_ar_q_empty", exp_ar.size(), 0);
    chk("end_r_q_empty", exp_r.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
